// File: rtl/fprint_pio_release_ctrl.sv
// Holds each redundant core's PIO write until the comparator releases the task key.
// Output regs update one cycle after the deciding input; cX_waitrequest is high while that core's slot is full.
module fprint_pio_release_ctrl #(
  parameter int DATA_W  = 4,
  parameter int TASK_W  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_write,
  input  logic [TASK_W-1:0] c0_task,
  input  logic [DATA_W-1:0] c0_data,
  output logic              c0_waitrequest,
  input  logic              c1_write,
  input  logic [TASK_W-1:0] c1_task,
  input  logic [DATA_W-1:0] c1_data,
  output logic              c1_waitrequest,
  input  logic              release_valid,
  input  logic [TASK_W-1:0] release_key,
  input  logic              release_ok,
  output logic [DATA_W-1:0] pio_out,
  output logic              pio_update,
  output logic              fault,
  output logic [2:0]        fault_code,
  output logic              busy
);

  localparam int TMR_W = $clog2(TIMEOUT);
  // Expiry is flagged one count early so the fault lands TIMEOUT cycles after the first write.
  localparam logic [TMR_W-1:0] TMR_EXP = TMR_W'(TIMEOUT - 2);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

  localparam logic [2:0] FC_DATA    = 3'd1;
  localparam logic [2:0] FC_FP      = 3'd2;
  localparam logic [2:0] FC_TIMEOUT = 3'd3;
  localparam logic [2:0] FC_STRAY   = 3'd4;
  localparam logic [2:0] FC_TASK    = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_ARMED} state_t;

  state_t            r_state;
  logic              r_s0_full;
  logic [TASK_W-1:0] r_s0_task;
  logic [DATA_W-1:0] r_s0_data;
  logic              r_s1_full;
  logic [TASK_W-1:0] r_s1_task;
  logic [DATA_W-1:0] r_s1_data;
  logic [TMR_W-1:0]  r_timer;
  logic              r_rel_seen;
  logic              r_rel_ok;
  logic [DATA_W-1:0] r_pio_out;
  logic              r_pio_update;
  logic              r_fault;
  logic [2:0]        r_fault_code;

  logic [TASK_W-1:0] w_held_task;
  logic [DATA_W-1:0] w_held_data;
  logic              w_in_write;
  logic [TASK_W-1:0] w_in_task;
  logic [DATA_W-1:0] w_in_data;
  logic              w_key_hit;
  logic              w_key_miss;
  logic              w_expire;
  logic [TMR_W-1:0]  w_timer_inc;
  logic              w_arm_done;
  logic              w_arm_ok;
  logic              w_both_write;

  assign c0_waitrequest = r_s0_full;
  assign c1_waitrequest = r_s1_full;
  assign busy           = (r_state != S_IDLE);
  assign pio_out        = r_pio_out;
  assign pio_update     = r_pio_update;
  assign fault          = r_fault;
  assign fault_code     = r_fault_code;

  // In CAPTURE exactly one slot is full; the other core supplies the second write.
  assign w_held_task  = r_s0_full ? r_s0_task : r_s1_task;
  assign w_held_data  = r_s0_full ? r_s0_data : r_s1_data;
  assign w_in_write   = r_s0_full ? c1_write  : c0_write;
  assign w_in_task    = r_s0_full ? c1_task   : c0_task;
  assign w_in_data    = r_s0_full ? c1_data   : c0_data;

  assign w_key_hit    = release_valid && (release_key == w_held_task);
  assign w_key_miss   = release_valid && (release_key != w_held_task);
  assign w_expire     = (r_timer >= TMR_EXP);
  assign w_timer_inc  = (r_timer == TMR_MAX) ? r_timer : r_timer + 1'b1;
  // A release latched during CAPTURE acts as if it arrived in the first ARMED cycle; a live one wins.
  assign w_arm_done   = w_key_hit || r_rel_seen;
  assign w_arm_ok     = w_key_hit ? release_ok : r_rel_ok;
  assign w_both_write = c0_write && c1_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_s0_full    <= 1'b0;
      r_s0_task    <= '0;
      r_s0_data    <= '0;
      r_s1_full    <= 1'b0;
      r_s1_task    <= '0;
      r_s1_data    <= '0;
      r_timer      <= '0;
      r_rel_seen   <= 1'b0;
      r_rel_ok     <= 1'b0;
      r_pio_out    <= '0;
      r_pio_update <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= 3'd0;
    end else begin
      r_pio_update <= 1'b0;
      r_fault      <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_timer    <= '0;
          r_rel_seen <= 1'b0;
          r_rel_ok   <= 1'b0;
          r_s0_task  <= c0_task;
          r_s0_data  <= c0_data;
          r_s1_task  <= c1_task;
          r_s1_data  <= c1_data;
          if (w_both_write && (c0_task != c1_task)) begin
            r_fault      <= 1'b1;
            r_fault_code <= FC_TASK;
          end else if (w_both_write && (c0_data != c1_data)) begin
            r_fault      <= 1'b1;
            r_fault_code <= FC_DATA;
          end else begin
            if (release_valid) begin
              r_fault      <= 1'b1;
              r_fault_code <= FC_STRAY;
            end
            r_s0_full <= c0_write;
            r_s1_full <= c1_write;
            if (w_both_write) begin
              r_state <= S_ARMED;
            end else if (c0_write || c1_write) begin
              r_state <= S_CAPTURE;
            end
          end
        end

        S_CAPTURE: begin
          if (w_in_write && (w_in_task != w_held_task)) begin
            r_fault      <= 1'b1;
            r_fault_code <= FC_TASK;
            r_s0_full    <= 1'b0;
            r_s1_full    <= 1'b0;
            r_rel_seen   <= 1'b0;
            r_state      <= S_IDLE;
          end else if (w_in_write && (w_in_data != w_held_data)) begin
            r_fault      <= 1'b1;
            r_fault_code <= FC_DATA;
            r_s0_full    <= 1'b0;
            r_s1_full    <= 1'b0;
            r_rel_seen   <= 1'b0;
            r_state      <= S_IDLE;
          end else if (w_expire) begin
            r_fault      <= 1'b1;
            r_fault_code <= FC_TIMEOUT;
            r_s0_full    <= 1'b0;
            r_s1_full    <= 1'b0;
            r_rel_seen   <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_timer <= w_timer_inc;
            if (w_in_write) begin
              r_s0_full <= 1'b1;
              r_s1_full <= 1'b1;
              r_state   <= S_ARMED;
              if (r_s0_full) begin
                r_s1_task <= c1_task;
                r_s1_data <= c1_data;
              end else begin
                r_s0_task <= c0_task;
                r_s0_data <= c0_data;
              end
            end
            if (w_key_hit) begin
              r_rel_seen <= 1'b1;
              r_rel_ok   <= release_ok;
            end else if (release_valid) begin
              r_fault      <= 1'b1;
              r_fault_code <= FC_STRAY;
            end
          end
        end

        S_ARMED: begin
          if (w_arm_done && w_arm_ok) begin
            r_pio_out    <= r_s0_data;
            r_pio_update <= 1'b1;
            r_s0_full    <= 1'b0;
            r_s1_full    <= 1'b0;
            r_rel_seen   <= 1'b0;
            r_state      <= S_IDLE;
            if (w_key_miss) begin
              r_fault      <= 1'b1;
              r_fault_code <= FC_STRAY;
            end
          end else if (w_arm_done) begin
            r_fault      <= 1'b1;
            r_fault_code <= FC_FP;
            r_s0_full    <= 1'b0;
            r_s1_full    <= 1'b0;
            r_rel_seen   <= 1'b0;
            r_state      <= S_IDLE;
          end else if (w_expire) begin
            r_fault      <= 1'b1;
            r_fault_code <= FC_TIMEOUT;
            r_s0_full    <= 1'b0;
            r_s1_full    <= 1'b0;
            r_rel_seen   <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_timer <= w_timer_inc;
            if (release_valid) begin
              r_fault      <= 1'b1;
              r_fault_code <= FC_STRAY;
            end
          end
        end

        default: begin
          r_s0_full  <= 1'b0;
          r_s1_full  <= 1'b0;
          r_rel_seen <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fprint_pio_release_ctrl.sv
// Directed vector bench for fprint_pio_release_ctrl (TIMEOUT = 16).
module tb_fprint_pio_release_ctrl;

  typedef struct packed {
    logic       rst;
    logic       w0;
    logic [3:0] t0;
    logic [3:0] d0;
    logic       w1;
    logic [3:0] t1;
    logic [3:0] d1;
    logic       rv;
    logic [3:0] rk;
    logic       ro;
  } in_t;

  typedef struct packed {
    logic       wr0;
    logic       wr1;
    logic [3:0] pio;
    logic       upd;
    logic       flt;
    logic [2:0] fc;
    logic       busy;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       c0_write, c1_write;
  logic [3:0] c0_task, c0_data, c1_task, c1_data;
  logic       c0_waitrequest, c1_waitrequest;
  logic       release_valid, release_ok;
  logic [3:0] release_key;
  logic [3:0] pio_out;
  logic       pio_update, fault, busy;
  logic [2:0] fault_code;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  fprint_pio_release_ctrl #(.DATA_W(4), .TASK_W(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .c0_write(c0_write), .c0_task(c0_task), .c0_data(c0_data), .c0_waitrequest(c0_waitrequest),
    .c1_write(c1_write), .c1_task(c1_task), .c1_data(c1_data), .c1_waitrequest(c1_waitrequest),
    .release_valid(release_valid), .release_key(release_key), .release_ok(release_ok),
    .pio_out(pio_out), .pio_update(pio_update), .fault(fault), .fault_code(fault_code), .busy(busy)
  );

  function automatic in_t inone();
    in_t x = '0;
    return x;
  endfunction

  function automatic in_t irst();
    in_t x = '0;
    x.rst = 1'b1;
    return x;
  endfunction

  function automatic in_t iw0(input logic [3:0] t, input logic [3:0] d);
    in_t x = '0;
    x.w0 = 1'b1; x.t0 = t; x.d0 = d;
    return x;
  endfunction

  function automatic in_t iw1(input logic [3:0] t, input logic [3:0] d);
    in_t x = '0;
    x.w1 = 1'b1; x.t1 = t; x.d1 = d;
    return x;
  endfunction

  function automatic in_t iwb(input logic [3:0] t, input logic [3:0] d);
    return in_t'(iw0(t, d) | iw1(t, d));
  endfunction

  function automatic in_t irel(input logic [3:0] k, input logic ok);
    in_t x = '0;
    x.rv = 1'b1; x.rk = k; x.ro = ok;
    return x;
  endfunction

  function automatic out_t O(input logic wr0, input logic wr1, input logic [3:0] pio,
                             input logic upd, input logic flt, input logic [2:0] fc, input logic bsy);
    out_t o;
    o.wr0 = wr0; o.wr1 = wr1; o.pio = pio; o.upd = upd; o.flt = flt; o.fc = fc; o.busy = bsy;
    return o;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    vq.push_back(v);
  endtask

  task automatic apply(input in_t x);
    reset         = x.rst;
    c0_write      = x.w0;  c0_task = x.t0; c0_data = x.d0;
    c1_write      = x.w1;  c1_task = x.t1; c1_data = x.d1;
    release_valid = x.rv;  release_key = x.rk; release_ok = x.ro;
  endtask

  task automatic check(input string nm, input int idx, input out_t e);
    out_t a;
    a.wr0 = c0_waitrequest; a.wr1 = c1_waitrequest; a.pio = pio_out; a.upd = pio_update;
    a.flt = fault; a.fc = fault_code; a.busy = busy;
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s[%0d]: got wr0=%b wr1=%b pio=%h upd=%b flt=%b fc=%0d busy=%b, want wr0=%b wr1=%b pio=%h upd=%b flt=%b fc=%0d busy=%b",
               nm, idx, a.wr0, a.wr1, a.pio, a.upd, a.flt, a.fc, a.busy,
               e.wr0, e.wr1, e.pio, e.upd, e.flt, e.fc, e.busy);
    end
  endtask

  // Both cores write at cycle 0 (ARMED from cycle 1); optionally release on the expiry cycle.
  task automatic arm_seq(input logic [3:0] t, input logic [3:0] d, input bit do_rel,
                         input logic [3:0] pio_before, input logic [2:0] fc_before);
    @(negedge clk);
    apply(iwb(t, d));
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      apply((c == 15 && do_rel) ? irel(t, 1'b1) : inone());
      #1;
      check(do_rel ? "arm_rel_hold" : "arm_to_hold", c, O(1, 1, pio_before, 0, 0, fc_before, 1));
    end
    @(negedge clk);
    apply(inone());
    #1;
    if (do_rel) check("arm_rel_at_expiry", 16, O(0, 0, d, 1, 0, fc_before, 0));
    else        check("arm_timeout", 16, O(0, 0, pio_before, 0, 1, 3'd3, 0));
  endtask

  initial begin
    // reset state
    add(irst(),                      O(0,0,4'h0,0,0,3'd0,0));
    // nominal: c0 @0, c1 @5, release @8
    add(iw0(4'd3, 4'hA),             O(0,0,4'h0,0,0,3'd0,0));
    for (int k = 0; k < 4; k++) add(inone(), O(1,0,4'h0,0,0,3'd0,1));
    add(iw1(4'd3, 4'hA),             O(1,0,4'h0,0,0,3'd0,1));
    add(inone(),                     O(1,1,4'h0,0,0,3'd0,1));
    add(inone(),                     O(1,1,4'h0,0,0,3'd0,1));
    add(irel(4'd3, 1'b1),            O(1,1,4'h0,0,0,3'd0,1));
    add(inone(),                     O(0,0,4'hA,1,0,3'd0,0));
    add(inone(),                     O(0,0,4'hA,0,0,3'd0,0));
    // data mismatch
    add(iw0(4'd2, 4'h5),             O(0,0,4'hA,0,0,3'd0,0));
    add(iw1(4'd2, 4'h6),             O(1,0,4'hA,0,0,3'd0,1));
    add(inone(),                     O(0,0,4'hA,0,1,3'd1,0));
    add(inone(),                     O(0,0,4'hA,0,0,3'd1,0));
    // task mismatch on simultaneous writes, then task beats data in CAPTURE
    add(in_t'(iw0(4'd1, 4'h3) | iw1(4'd2, 4'h3)), O(0,0,4'hA,0,0,3'd1,0));
    add(inone(),                     O(0,0,4'hA,0,1,3'd5,0));
    add(iw1(4'd4, 4'h9),             O(0,0,4'hA,0,0,3'd5,0));
    add(iw0(4'd5, 4'h1),             O(0,1,4'hA,0,0,3'd5,1));
    add(inone(),                     O(0,0,4'hA,0,1,3'd5,0));
    // early release ok=0 -> FP_MISMATCH one cycle after ARMED entry
    add(iw0(4'd4, 4'h2),             O(0,0,4'hA,0,0,3'd5,0));
    add(irel(4'd4, 1'b0),            O(1,0,4'hA,0,0,3'd5,1));
    add(iw1(4'd4, 4'h2),             O(1,0,4'hA,0,0,3'd5,1));
    add(inone(),                     O(1,1,4'hA,0,0,3'd5,1));
    add(inone(),                     O(0,0,4'hA,0,1,3'd2,0));
    // second early release overwrites the first
    add(iw1(4'd6, 4'h8),             O(0,0,4'hA,0,0,3'd2,0));
    add(irel(4'd6, 1'b0),            O(0,1,4'hA,0,0,3'd2,1));
    add(irel(4'd6, 1'b1),            O(0,1,4'hA,0,0,3'd2,1));
    add(iw0(4'd6, 4'h8),             O(0,1,4'hA,0,0,3'd2,1));
    add(inone(),                     O(1,1,4'hA,0,0,3'd2,1));
    add(inone(),                     O(0,0,4'h8,1,0,3'd2,0));
    // minimum task cycle; write during release cycle is held, next one accepted
    add(iwb(4'd9, 4'hC),             O(0,0,4'h8,0,0,3'd2,0));
    add(in_t'(irel(4'd9, 1'b1) | iw0(4'd1, 4'h1)), O(1,1,4'h8,0,0,3'd2,1));
    add(iw0(4'd11, 4'h3),            O(0,0,4'hC,1,0,3'd2,0));
    // timeout from that write: held c0 write @3, stray key @5, fault @16
    for (int k = 1; k <= 15; k++)
      add((k == 3) ? iw0(4'd0, 4'h0) : (k == 5) ? irel(4'd5, 1'b1) : inone(),
          O(1,0,4'hC,0,(k == 6),(k >= 6) ? 3'd4 : 3'd2,1));
    add(inone(),                     O(0,0,4'hC,0,1,3'd3,0));
    // simultaneous writes, stray key in ARMED, then real release
    add(iwb(4'd7, 4'hF),             O(0,0,4'hC,0,0,3'd3,0));
    add(irel(4'd6, 1'b1),            O(1,1,4'hC,0,0,3'd3,1));
    add(inone(),                     O(1,1,4'hC,0,1,3'd4,1));
    add(irel(4'd7, 1'b1),            O(1,1,4'hC,0,0,3'd4,1));
    add(inone(),                     O(0,0,4'hF,1,0,3'd4,0));
    // stray release in IDLE
    add(irel(4'd7, 1'b1),            O(0,0,4'hF,0,0,3'd4,0));
    add(inone(),                     O(0,0,4'hF,0,1,3'd4,0));
    // reset mid-ARMED
    add(iwb(4'd7, 4'h1),             O(0,0,4'hF,0,0,3'd4,0));
    add(irst(),                      O(1,1,4'hF,0,0,3'd4,1));
    add(irel(4'd7, 1'b1),            O(0,0,4'h0,0,0,3'd0,0));
    add(inone(),                     O(0,0,4'h0,0,1,3'd4,0));
    add(inone(),                     O(0,0,4'h0,0,0,3'd4,0));

    apply(irst());
    repeat (2) @(posedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      apply(vq[i].i);
      #1;
      check("vec", i, vq[i].o);
    end

    arm_seq(4'd2, 4'h4, 1'b1, 4'h0, 3'd4);
    arm_seq(4'd3, 4'h5, 1'b0, 4'h4, 3'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fprint_pio_release_ctrl.md
# fprint_pio_release_ctrl

Output-release controller for the dual-core fingerprinting system. It accepts the external PIO write made by each redundant core for the current task and holds that write back. It drives the shared external PIO only after the fingerprint comparator releases the matching task key. One write per task cycle, so the block has a single holding slot per core and no FIFO. It sits between the two core PIO write paths and the board-level PIO pins (e.g. the LED bank).

## Interface
Parameters:
- DATA_W, 4, width of external PIO value
- TASK_W, 4, width of task ID / release key
- TIMEOUT, 1024, cycles allowed from first accepted write to release (≥2)

Ports:
- clk  in  1  system clock (all logic on rising edge)
- reset  in  1  synchronous, active-high reset
- c0_write  in  1  core 0 write strobe
- c0_task  in  TASK_W  core 0 task ID for this write
- c0_data  in  DATA_W  core 0 PIO value
- c0_waitrequest  out  1  core 0 write not accepted this cycle
- c1_write, c1_task, c1_data, c1_waitrequest  same widths and directions, core 1
- release_valid  in  1  comparator release strobe
- release_key  in  TASK_W  task the release applies to
- release_ok  in  1  1 = fingerprints matched, 0 = mismatch
- pio_out  out  DATA_W  external PIO value (registered)
- pio_update  out  1  one-cycle pulse when pio_out is loaded
- fault  out  1  one-cycle fault pulse
- fault_code  out  3  valid with fault: 1 DATA_MISMATCH, 2 FP_MISMATCH, 3 TIMEOUT, 4 STRAY_RELEASE, 5 TASK_MISMATCH
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, CAPTURE, ARMED.
- **Write acceptance:**
  - A core's write is accepted when its write strobe = 1 and its waitrequest = 0.
  - cX_waitrequest = 1 while that core's slot is full (CAPTURE or ARMED), otherwise 0.
- **IDLE:**
  - One core writes: store task and data in that core's slot, set the slot full, clear the timer, go to CAPTURE.
  - Both cores write in the same cycle: store both slots and compare immediately (see the ARMED entry rules).
- **CAPTURE, second core writes:**
  - Task IDs differ: fault TASK_MISMATCH, clear both slots, go to IDLE.
  - Task IDs equal, data differs: fault DATA_MISMATCH, clear, go to IDLE.
  - Task IDs and data both equal: go to ARMED.
- **ARMED:**
  - release_valid with release_key = stored task and release_ok = 1: load pio_out with the stored data, pulse pio_update, clear the slots, go to IDLE.
  - Same release with release_ok = 0: fault FP_MISMATCH, pio_out unchanged, clear, go to IDLE.
- **Early release:**
  - release_valid with a matching key while in CAPTURE latches release_seen and release_ok_q.
  - Both are applied in the cycle ARMED is entered, exactly as if the release arrived there.
  - A second early release overwrites the latch.
- **Stray release:**
  - Any of these raises fault STRAY_RELEASE and leaves state unchanged: release_valid in IDLE, or a key not equal to the stored task in CAPTURE/ARMED.
- **Timeout:**
  - The timer counts every cycle in CAPTURE and ARMED.
  - When the timer reaches TIMEOUT−1 with no completing event that cycle: fault TIMEOUT, clear, go to IDLE.
  - The timer saturates and never wraps.
- **Simultaneous events:**
  - A completing release or a compare fault in the same cycle as timer expiry takes priority over TIMEOUT.
  - Only one fault code is reported per cycle. Priority: TASK_MISMATCH > DATA_MISMATCH > FP_MISMATCH > TIMEOUT > STRAY_RELEASE.
  - A lower-priority fault in the same cycle is dropped.
- Writes arriving in the cycle the block returns to IDLE are not accepted: waitrequest is still 1 that cycle.

## Timing
- Reset values: pio_out = 0, pio_update = 0, fault = 0, fault_code = 0, busy = 0, waitrequest = 0, all slots empty, state IDLE.
- Reset mid-operation discards all pending data with no pio_update and no fault.
- All outputs are registered.
- pio_out, pio_update, fault and fault_code appear one cycle after the triggering input edge.
- waitrequest is combinational from state and slot flags only, never from cX_write.
- Minimum task cycle: both writes at cycle N and release at N+1 gives pio_out valid at N+2. The next write is accepted at N+2.
- fault_code holds its last value between pulses; only the fault pulse qualifies it.

## Test plan
- **Nominal, sequential writes:** c0 writes task 3 data 0xA at cycle 0, c1 writes task 3 data 0xA at cycle 5, release key 3 ok = 1 at cycle 8 → pio_out = 0xA at cycle 9, pio_update pulses once, busy falls.
- **Data mismatch:** c0 writes task 2 data 0x5, c1 writes task 2 data 0x6 → fault with code 1, pio_out keeps its previous value, IDLE.
- **Fingerprint mismatch and early release:** release key 4 ok = 0 arrives while in CAPTURE for task 4, then c1 write completes → FP_MISMATCH fault in the cycle after ARMED entry, no pio_update.
- **Timeout with TIMEOUT = 16:** only c0 writes at cycle 0 → fault code 3 at cycle 16. A c0 write at cycle 3 is held by waitrequest = 1.
- **Simultaneous writes, then a stray release:** c0 and c1 both write task 7 data 0xF in the same cycle → ARMED next cycle. A release with key 6 gives code 4 and state stays ARMED. A release with key 7 ok = 1 then gives pio_out = 0xF.
- **Reset mid-ARMED:** reset asserted for 1 cycle, then a release with key 7 ok = 1 → all outputs 0, and the release gives STRAY_RELEASE.
